bigmul_mac_unit: RTL
====================

# bigmul_mac_unit

Parametrised product-scanning big-integer multiply/multiply-accumulate engine; next generation of the 4096-bit BIGMUL accelerator. Operands and result live in internal limb memories loaded and read through a single host access port while idle. One start computes R = A·B or, in MAC mode, R = R + A·B, column by column with PARALLEL limb multipliers per cycle. Sits behind the core's accelerator register interface, same as the existing BIGMUL unit.

## Interface
- LIMB_W, 64, bits per limb
- NUM_LIMBS, 64, limbs per operand (N); result has 2N limbs
- PARALLEL, 8, limb products per cycle (P), 1 ≤ P ≤ N
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin operation; sampled only in IDLE
- mode  in  1  0 = MUL, 1 = MAC; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- ovf  out  1  MAC carry out of limb 2N-1 on last operation
- mem_we  in  1  host write strobe
- mem_sel  in  2  0 = A, 1 = B, 2 = R, 3 = reserved
- mem_addr  in  clog2(2N)  limb index
- mem_wdata  in  LIMB_W  write data
- mem_rdata  out  LIMB_W  registered read data
- cycles_out  out  64  busy cycles of last operation

## Operation
- States: IDLE, RUN, FIN. IDLE→RUN on start; RUN→FIN after last group of column 2N-2; FIN→IDLE unconditionally.
- Host port active only in IDLE: write when mem_we; read data of (sel, addr) appears on mem_rdata next cycle. While busy: writes ignored, mem_rdata = 0. sel 3, or addr ≥ N for A/B: write ignored, read 0.
- Column d (0..2N-2) has n_d = min(d, 2N-2-d)+1 products A[i]·B[d-i]; processed in ceil(n_d/P) groups, one per cycle, lowest i first.
- Accumulator ACC_W = 2·LIMB_W + clog2(N) + 2 bits. First group of column d adds carry-in plus (MAC) old R[d]; each group adds its products. At a column's last group R[d] ← acc[LIMB_W-1:0], acc ← acc >> LIMB_W.
- FIN: R[2N-1] ← acc low limb (plus old R[2N-1] in MAC); ovf ← any remaining carry (always 0 in MUL).
- MUL overwrites all 2N R limbs; A and B never modified.
- start while busy ignored; mode is held internally, changes during RUN ignored.

## Timing
- Reset: busy=0, done=0, ovf=0, mem_rdata=0, cycles_out=0, state IDLE. Memories not reset. rst mid-operation aborts immediately; R contents then undefined.
- Start accepted cycle t: busy=1 from t+1 through last FIN cycle; L = Σ ceil(n_d/P) + 1 busy cycles; done=1 and busy=0 at cycle t+L+1.
- Results and ovf readable from the done cycle on.
- N=4,P=4: L=8. N=4,P=2: L=11.

## Configuration
- BIGMUL_CYCLE_CNT_EN defined: 64-bit counter cleared on start, increments each busy cycle, copied to cycles_out at done (equals L).
- Undefined: no counter; cycles_out tied 0.

## Structure
- Package bigmul_pkg: state enum, mem_sel encodings, mode encodings, clog2 function, ACC_W derivation.
- One sub-module bigmul_col_group: combinational P multipliers plus adder tree returning group sum; top holds FSM, memories, accumulator, host port.

## Test plan
- N=4,P=4,MUL, A=B=all-ones limbs -> R = (2^256-1)^2, done at t+9, cycles_out=8 (macro on), ovf=0.
- N=4,P=2,MUL, A=1, B=random -> R low 4 limbs = B, high 4 = 0, L=11.
- MAC, R preset all-ones, A=1, B=1 -> R=0, ovf=1.
- mem_we to A and start asserted while busy -> A unchanged, no restart, mem_rdata=0.
- rst asserted mid-RUN -> next cycle busy=0, done=0; new start completes correctly.
- Random N=8,P=3 MUL and MAC vs. software model over 200 vectors -> exact match.

Source files
------------

// File: rtl/bigmul_pkg.sv
// Shared types and sizing helpers for the product-scanning big-integer MUL/MAC engine.
package bigmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Host port memory selectors; encoding 3 is reserved and reads back 0.
  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_R = 2'd2;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned x);
    int unsigned r;
    r = 0;
    for (int unsigned v = x - 1; v > 0; v = v >> 1) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  // Column accumulator: two-limb product, log2(N) growth, plus carry-in and old R limb.
  function automatic int unsigned acc_w(input int unsigned limb_w, input int unsigned n);
    return 2 * limb_w + clog2(n) + 2;
  endfunction

endpackage

// File: rtl/bigmul_col_group.sv
// One column group: PARALLEL limb multipliers summed into a single accumulator-wide value.
module bigmul_col_group
  import bigmul_pkg::*;
#(
  parameter int unsigned LIMB_W   = 64,
  parameter int unsigned PARALLEL = 8,
  parameter int unsigned SUM_W    = acc_w(LIMB_W, PARALLEL)
) (
  input  logic [PARALLEL-1:0][LIMB_W-1:0] a_i,
  input  logic [PARALLEL-1:0][LIMB_W-1:0] b_i,
  output logic [SUM_W-1:0]                sum_o
);

  localparam int unsigned PW = 2 * LIMB_W;

  logic [PARALLEL-1:0][PW-1:0] prod_c;

  // Unused lanes arrive as zero operands, so they contribute nothing to the sum.
  always_comb begin
    sum_o = '0;
    for (int k = 0; k < PARALLEL; k++) begin
      prod_c[k] = PW'(a_i[k]) * PW'(b_i[k]);
      sum_o     = sum_o + SUM_W'(prod_c[k]);
    end
  end

endmodule

// File: rtl/bigmul_mac_unit.sv
// Big-integer R = A*B / R = R + A*B engine with limb memories behind a single host port.
// Optional busy-cycle counter on cycles_out when BIGMUL_CYCLE_CNT_EN is defined.
module bigmul_mac_unit
  import bigmul_pkg::*;
#(
  parameter int unsigned LIMB_W    = 64,
  parameter int unsigned NUM_LIMBS = 64,
  parameter int unsigned PARALLEL  = 8,
  localparam int unsigned AW       = clog2(2 * NUM_LIMBS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  input  logic              mem_we,
  input  logic [1:0]        mem_sel,
  input  logic [AW-1:0]     mem_addr,
  input  logic [LIMB_W-1:0] mem_wdata,
  output logic [LIMB_W-1:0] mem_rdata,
  output logic [63:0]       cycles_out
);

  localparam int unsigned N2    = 2 * NUM_LIMBS;
  localparam int unsigned IW    = clog2(NUM_LIMBS);
  localparam int unsigned ACC_W = acc_w(LIMB_W, NUM_LIMBS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LIMBS - 1);
  localparam logic [AW-1:0] LAST_COL = AW'(N2 - 2);
  localparam logic [AW-1:0] TOP_LIMB = AW'(N2 - 1);

  logic [LIMB_W-1:0] a_mem [NUM_LIMBS];
  logic [LIMB_W-1:0] b_mem [NUM_LIMBS];
  logic [LIMB_W-1:0] r_mem [N2];

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [AW-1:0]     col_q, col_d, i_q, i_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [LIMB_W-1:0] rdata_q, rdata_d;

  logic [AW-1:0]     i_lo_c, i_hi_c, col_nxt_c, i_lo_nxt_c;
  logic [AW-1:0]     idx_c [PARALLEL];
  logic [PARALLEL-1:0][LIMB_W-1:0] a_op_c, b_op_c;
  logic [ACC_W-1:0]  grp_sum_c, sum_c;
  logic              first_c, last_c;
  logic              r_we_c;
  logic [AW-1:0]     r_waddr_c;
  logic [LIMB_W-1:0] r_wdata_c, rd_c;
  logic              ab_ok_c, r_ok_c;

  // Column bounds: column d pairs A[i] with B[d-i] for i in [i_lo, i_hi].
  always_comb begin
    col_nxt_c  = col_q + AW'(1);
    i_lo_c     = (col_q > LAST_IDX) ? col_q - LAST_IDX : '0;
    i_hi_c     = (col_q < LAST_IDX) ? col_q : LAST_IDX;
    i_lo_nxt_c = (col_nxt_c > LAST_IDX) ? col_nxt_c - LAST_IDX : '0;
    first_c    = (i_q == i_lo_c);
    last_c     = ({1'b0, i_q} + (AW + 1)'(PARALLEL)) > {1'b0, i_hi_c};
    for (int k = 0; k < PARALLEL; k++) begin
      idx_c[k]  = i_q + AW'(k);
      a_op_c[k] = '0;
      b_op_c[k] = '0;
      if (idx_c[k] <= i_hi_c) begin
        a_op_c[k] = a_mem[IW'(idx_c[k])];
        b_op_c[k] = b_mem[IW'(col_q - idx_c[k])];
      end
    end
  end

  bigmul_col_group #(
    .LIMB_W   (LIMB_W),
    .PARALLEL (PARALLEL),
    .SUM_W    (ACC_W)
  ) u_col_group (
    .a_i   (a_op_c),
    .b_i   (b_op_c),
    .sum_o (grp_sum_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    col_d     = col_q;
    i_d       = i_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    r_we_c    = 1'b0;
    r_waddr_c = col_q;
    r_wdata_c = '0;
    sum_c     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = mode;
          col_d   = '0;
          i_d     = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      ST_RUN: begin
        sum_c = acc_q + grp_sum_c
              + ((first_c && mode_q == MODE_MAC) ? ACC_W'(r_mem[col_q]) : '0);
        if (last_c) begin
          r_we_c    = 1'b1;
          r_wdata_c = sum_c[LIMB_W-1:0];
          acc_d     = sum_c >> LIMB_W;
          if (col_q == LAST_COL) begin
            state_d = ST_FIN;
          end else begin
            col_d = col_nxt_c;
            i_d   = i_lo_nxt_c;
          end
        end else begin
          acc_d = sum_c;
          i_d   = i_q + AW'(PARALLEL);
        end
      end
      ST_FIN: begin
        sum_c     = acc_q + ((mode_q == MODE_MAC) ? ACC_W'(r_mem[TOP_LIMB]) : '0);
        r_we_c    = 1'b1;
        r_waddr_c = TOP_LIMB;
        r_wdata_c = sum_c[LIMB_W-1:0];
        ovf_d     = |sum_c[ACC_W-1:LIMB_W];
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Host read mux; the registered copy is forced to 0 whenever the next cycle is busy.
  always_comb begin
    ab_ok_c = mem_addr < AW'(NUM_LIMBS);
    r_ok_c  = {1'b0, mem_addr} < (AW + 1)'(N2);
    rd_c    = '0;
    case (mem_sel)
      SEL_A:   if (ab_ok_c) rd_c = a_mem[IW'(mem_addr)];
      SEL_B:   if (ab_ok_c) rd_c = b_mem[IW'(mem_addr)];
      SEL_R:   if (r_ok_c)  rd_c = r_mem[mem_addr];
      default: rd_c = '0;
    endcase
    rdata_d = (state_q == ST_IDLE && !start) ? rd_c : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MUL;
      col_q   <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  // Limb memories are not reset; host writes only land while idle.
  always_ff @(posedge clk) begin
    if (mem_we && state_q == ST_IDLE) begin
      case (mem_sel)
        SEL_A:   if (ab_ok_c) a_mem[IW'(mem_addr)] <= mem_wdata;
        SEL_B:   if (ab_ok_c) b_mem[IW'(mem_addr)] <= mem_wdata;
        SEL_R:   if (r_ok_c)  r_mem[mem_addr] <= mem_wdata;
        default: ;
      endcase
    end
    if (r_we_c) r_mem[r_waddr_c] <= r_wdata_c;
  end

`ifdef BIGMUL_CYCLE_CNT_EN
  logic [63:0] cnt_q, cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start) cnt_q <= '0;
      else if (busy_q)                 cnt_q <= cnt_q + 64'd1;
      if (state_q == ST_FIN)           cyc_q <= cnt_q + 64'd1;
    end
  end

  assign cycles_out = cyc_q;
`else
  assign cycles_out = '0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign mem_rdata = rdata_q;

endmodule
